// File: rtl/hex_expr_parser_pkg.sv
// Shared constants and types for the hex calculator command parser:
// ASCII codes, operator and error encodings, FSM state type.
package hex_expr_parser_pkg;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_ESC   = 8'h1B;
   localparam logic [7:0] CH_EQ    = 8'h3D;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_MUL   = 8'h2A;
   localparam logic [7:0] CH_DIV   = 8'h2F;
   localparam logic [7:0] CH_S     = 8'h53;
   localparam logic [7:0] CH_U     = 8'h55;
   localparam logic [7:0] CH_I     = 8'h49;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_MUL  = 3'd3,
      OP_DIV  = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_BADCHAR = 2'd1,
      ERR_OVF     = 2'd2,
      ERR_SYNTAX  = 2'd3
   } err_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPA,
      ST_OPB,
      ST_FLUSH,
      ST_DONE
   } state_e;

   function automatic op_e op_decode(input logic [7:0] c);
      case (c)
         CH_PLUS:  return OP_ADD;
         CH_MINUS: return OP_SUB;
         CH_MUL:   return OP_MUL;
         CH_DIV:   return OP_DIV;
         default:  return OP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/hex_expr_parser_if.sv
// Byte-stream input and parsed-command output handshakes of the hex expression parser.
// master drives received bytes and consumes commands; slave is the parser.
interface hex_expr_parser_if #(parameter int DIGITS = 4) ();
   localparam int W = 4 * DIGITS;

   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         rx_ready;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_signed;
   logic         cmd_int;
   logic [2:0]   cmd_op;
   logic [W-1:0] cmd_src1;
   logic [W-1:0] cmd_src2;
   logic         cmd_err;
   logic [1:0]   cmd_err_code;

   modport master (
      output rx_data, rx_valid, cmd_ready,
      input  rx_ready, cmd_valid, cmd_signed, cmd_int, cmd_op,
             cmd_src1, cmd_src2, cmd_err, cmd_err_code
   );

   modport slave (
      input  rx_data, rx_valid, cmd_ready,
      output rx_ready, cmd_valid, cmd_signed, cmd_int, cmd_op,
             cmd_src1, cmd_src2, cmd_err, cmd_err_code
   );
endinterface

// File: rtl/hex_expr_parser_ascii2nib.sv
// Combinational ASCII hex digit decoder; lowercase digits optional.
module hex_ascii_to_nibble
   import hex_expr_parser_pkg::*;
#(
   parameter int ALLOW_LOWER = 1
) (
   input  logic [7:0] byte_i,
   output logic       is_hex_o,
   output logic [3:0] nib_o
);

   // Letters map via low nibble: 'A'/'a' = x1, so +9 gives 10.
   always_comb begin
      is_hex_o = 1'b0;
      nib_o    = 4'd0;
      if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
         is_hex_o = 1'b1;
         nib_o    = byte_i[3:0];
      end else if (byte_i >= 8'h41 && byte_i <= 8'h46) begin
         is_hex_o = 1'b1;
         nib_o    = byte_i[3:0] + 4'd9;
      end else if (ALLOW_LOWER != 0 && byte_i >= 8'h61 && byte_i <= 8'h66) begin
         is_hex_o = 1'b1;
         nib_o    = byte_i[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/hex_expr_parser.sv
// ASCII command parser: "[S|U][I] <hexA> <op> <hexB> =" -> one command per '='
// with sticky first-error reporting, ESC abort and signed operand extension.
module hex_expr_parser
   import hex_expr_parser_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int ALLOW_LOWER = 1
) (
   input logic              clk,
   input logic              n_rst,
   hex_expr_parser_if.slave bus
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   state_e        state_q;
   logic          rx_ready_q;
   logic          cmd_valid_q;
   logic          signed_q;
   logic          int_q;
   op_e           op_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [CW-1:0] cnta_q;
   logic [CW-1:0] cntb_q;
   logic          err_q;
   err_e          code_q;

   logic          is_hex;
   logic [3:0]    nib;
   op_e           op_in;
   logic          acc;
   logic          clear_d;
   logic [W-1:0]  a_shift_d;
   logic [W-1:0]  b_shift_d;

   hex_ascii_to_nibble #(.ALLOW_LOWER(ALLOW_LOWER)) u_nib (
      .byte_i   (bus.rx_data),
      .is_hex_o (is_hex),
      .nib_o    (nib)
   );

   assign op_in     = op_decode(bus.rx_data);
   assign acc       = bus.rx_valid & rx_ready_q;
   assign clear_d   = (state_q == ST_DONE && bus.cmd_ready) || (acc && bus.rx_data == CH_ESC);
   assign a_shift_d = (a_q << 4) | W'(nib);
   assign b_shift_d = (b_q << 4) | W'(nib);

   // Short signed operands take their top digit's MSB as sign.
   function automatic logic [W-1:0] sext(input logic [W-1:0] v, input logic [CW-1:0] n,
                                         input logic sgn);
      logic [W-1:0] r;
      r = v;
      if (sgn) begin
         for (int k = 1; k < DIGITS; k++) begin
            if (n == CW'(k) && v[4*k-1]) r = v | ({W{1'b1}} << (4 * k));
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         rx_ready_q  <= 1'b1;
         cmd_valid_q <= 1'b0;
         signed_q    <= 1'b0;
         int_q       <= 1'b0;
         op_q        <= OP_NONE;
         a_q         <= '0;
         b_q         <= '0;
         cnta_q      <= '0;
         cntb_q      <= '0;
         err_q       <= 1'b0;
         code_q      <= ERR_NONE;
      end else if (clear_d) begin
         state_q     <= ST_IDLE;
         rx_ready_q  <= 1'b1;
         cmd_valid_q <= 1'b0;
         signed_q    <= 1'b0;
         int_q       <= 1'b0;
         op_q        <= OP_NONE;
         a_q         <= '0;
         b_q         <= '0;
         cnta_q      <= '0;
         cntb_q      <= '0;
         err_q       <= 1'b0;
         code_q      <= ERR_NONE;
      end else if (acc && bus.rx_data != CH_SPACE) begin
         if (bus.rx_data == CH_EQ) begin
            // '=' ends the command from every receiving state; FLUSH keeps its error.
            state_q     <= ST_DONE;
            cmd_valid_q <= 1'b1;
            rx_ready_q  <= 1'b0;
            case (state_q)
               ST_IDLE, ST_OPA: begin
                  err_q  <= 1'b1;
                  code_q <= ERR_SYNTAX;
               end
               ST_OPB: begin
                  if (cntb_q == '0) begin
                     err_q  <= 1'b1;
                     code_q <= ERR_SYNTAX;
                  end else begin
                     b_q <= sext(b_q, cntb_q, signed_q);
                  end
               end
               default: ;
            endcase
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (bus.rx_data == CH_S) begin
                     signed_q <= 1'b1;
                  end else if (bus.rx_data == CH_U) begin
                     signed_q <= 1'b0;
                  end else if (bus.rx_data == CH_I) begin
                     int_q <= 1'b1;
                  end else if (is_hex) begin
                     a_q     <= W'(nib);
                     cnta_q  <= CW'(1);
                     state_q <= ST_OPA;
                  end else begin
                     err_q   <= 1'b1;
                     code_q  <= (op_in != OP_NONE) ? ERR_SYNTAX : ERR_BADCHAR;
                     state_q <= ST_FLUSH;
                  end
               end
               ST_OPA: begin
                  if (is_hex) begin
                     if (cnta_q == CW'(DIGITS)) begin
                        err_q   <= 1'b1;
                        code_q  <= ERR_OVF;
                        state_q <= ST_FLUSH;
                     end else begin
                        a_q    <= a_shift_d;
                        cnta_q <= cnta_q + CW'(1);
                     end
                  end else if (op_in != OP_NONE) begin
                     op_q    <= op_in;
                     a_q     <= sext(a_q, cnta_q, signed_q);
                     state_q <= ST_OPB;
                  end else begin
                     err_q   <= 1'b1;
                     code_q  <= ERR_BADCHAR;
                     state_q <= ST_FLUSH;
                  end
               end
               ST_OPB: begin
                  if (is_hex) begin
                     if (cntb_q == CW'(DIGITS)) begin
                        err_q   <= 1'b1;
                        code_q  <= ERR_OVF;
                        state_q <= ST_FLUSH;
                     end else begin
                        b_q    <= b_shift_d;
                        cntb_q <= cntb_q + CW'(1);
                     end
                  end else begin
                     err_q   <= 1'b1;
                     code_q  <= (op_in != OP_NONE) ? ERR_SYNTAX : ERR_BADCHAR;
                     state_q <= ST_FLUSH;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.rx_ready     = rx_ready_q;
   assign bus.cmd_valid    = cmd_valid_q;
   assign bus.cmd_signed   = signed_q;
   assign bus.cmd_int      = int_q;
   assign bus.cmd_op       = op_q;
   assign bus.cmd_src1     = a_q;
   assign bus.cmd_src2     = b_q;
   assign bus.cmd_err      = err_q;
   assign bus.cmd_err_code = code_q;

endmodule

// File: tb/tb_hex_expr_parser.sv
// Bench for hex_expr_parser: two instances (4 digits/lowercase, 3 digits/uppercase only)
// share one byte stream and are checked every cycle against a string-level parse model.
module tb_hex_expr_parser;

   typedef struct {
      logic        sg;
      logic        it;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        err;
      logic [1:0]  code;
   } exp_t;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       cmd_ready = 1'b0;
   bit         rdy_rand = 1'b0;
   bit         gap_en = 1'b0;
   bit         chk_en = 1'b0;
   bit         pending = 1'b0;
   int         n_tests = 0;
   int         n_fail = 0;
   exp_t       exp0_q[$];
   exp_t       exp1_q[$];
   logic [7:0] cur[$];

   always #5 clk = ~clk;

   hex_expr_parser_if #(.DIGITS(4)) if0 ();
   hex_expr_parser_if #(.DIGITS(3)) if1 ();

   assign if0.rx_data   = rx_data;
   assign if0.rx_valid  = rx_valid;
   assign if0.cmd_ready = cmd_ready;
   assign if1.rx_data   = rx_data;
   assign if1.rx_valid  = rx_valid;
   assign if1.cmd_ready = cmd_ready;

   hex_expr_parser #(.DIGITS(4), .ALLOW_LOWER(1)) dut0 (.clk(clk), .n_rst(n_rst), .bus(if0.slave));
   hex_expr_parser #(.DIGITS(3), .ALLOW_LOWER(0)) dut1 (.clk(clk), .n_rst(n_rst), .bus(if1.slave));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: string-level parse ----------------
   function automatic bit is_hx(input logic [7:0] c, input bit lower);
      return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (lower && c >= "a" && c <= "f");
   endfunction

   function automatic int hval(input logic [7:0] c);
      if (c <= "9") return int'(c) - 48;
      if (c <= "F") return int'(c) - 55;
      return int'(c) - 87;
   endfunction

   function automatic int opc(input logic [7:0] c);
      if (c == "+") return 1;
      if (c == "-") return 2;
      if (c == "*") return 3;
      if (c == "/") return 4;
      return 0;
   endfunction

   function automatic longint extend(input longint v, input int n, input int dg, input bit sg);
      if (sg && n < dg && v >= (longint'(1) << (4 * n - 1)))
         return v + (longint'(1) << (4 * dg)) - (longint'(1) << (4 * n));
      return v;
   endfunction

   function automatic exp_t model(input logic [7:0] q[$], input int dg, input bit lower);
      exp_t e;
      logic [7:0] s[$];
      int n, i, j, k, m;
      longint va, vb;
      e = '{sg: 1'b0, it: 1'b0, op: 3'd0, a: 32'd0, b: 32'd0, err: 1'b0, code: 2'd0};
      foreach (q[x]) if (q[x] != " ") s.push_back(q[x]);
      n = s.size();
      i = 0;
      while (i < n && (s[i] == "S" || s[i] == "U" || s[i] == "I")) begin
         if (s[i] == "S") e.sg = 1'b1;
         else if (s[i] == "U") e.sg = 1'b0;
         else e.it = 1'b1;
         i++;
      end
      va = 0;
      j = i;
      while (j < n && is_hx(s[j], lower)) begin va = va * 16 + hval(s[j]); j++; end
      e.err = 1'b1;
      if (j == i) begin e.code = (i < n && opc(s[i]) == 0) ? 2'd1 : 2'd3; return e; end
      if (j - i > dg) begin e.code = 2'd2; return e; end
      if (j == n) begin e.code = 2'd3; return e; end
      if (opc(s[j]) == 0) begin e.code = 2'd1; return e; end
      e.op = 3'(opc(s[j]));
      k = j + 1;
      m = k;
      vb = 0;
      while (m < n && is_hx(s[m], lower)) begin vb = vb * 16 + hval(s[m]); m++; end
      if (m - k > dg) begin e.code = 2'd2; return e; end
      if (m == k) begin e.code = (k < n && opc(s[k]) == 0) ? 2'd1 : 2'd3; return e; end
      if (m < n) begin e.code = (opc(s[m]) != 0) ? 2'd3 : 2'd1; return e; end
      e.err = 1'b0;
      e.a = 32'(extend(va, j - i, dg, e.sg));
      e.b = 32'(extend(vb, m - k, dg, e.sg));
      return e;
   endfunction

   function automatic exp_t model_s(input string str, input int dg, input bit lower);
      logic [7:0] q[$];
      for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
      return model(q, dg, lower);
   endfunction

   // Track accepted bytes and outstanding commands at each clock edge.
   initial begin
      forever begin
         @(posedge clk or negedge n_rst);
         if (!n_rst) begin
            pending = 1'b0;
            cur.delete();
            exp0_q.delete();
            exp1_q.delete();
         end else if (pending) begin
            if (cmd_ready) begin
               pending = 1'b0;
               void'(exp0_q.pop_front());
               void'(exp1_q.pop_front());
            end
         end else if (rx_valid) begin
            if (rx_data == 8'h1B) begin
               cur.delete();
            end else if (rx_data == "=") begin
               exp0_q.push_back(model(cur, 4, 1'b1));
               exp1_q.push_back(model(cur, 3, 1'b0));
               cur.delete();
               pending = 1'b1;
            end else begin
               cur.push_back(rx_data);
            end
         end
      end
   end

   task automatic cmp_cmd(input string t, input logic sg, input logic it, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic err,
                          input logic [1:0] code, input exp_t e);
      chk({t, "_signed"}, 32'(sg), 32'(e.sg));
      chk({t, "_int"}, 32'(it), 32'(e.it));
      chk({t, "_err"}, 32'(err), 32'(e.err));
      chk({t, "_code"}, 32'(code), 32'(e.code));
      if (!e.err) begin
         chk({t, "_op"}, 32'(op), 32'(e.op));
         chk({t, "_src1"}, a, e.a);
         chk({t, "_src2"}, b, e.b);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("rx_ready0", 32'(if0.rx_ready), 32'(!pending));
            chk("rx_ready1", 32'(if1.rx_ready), 32'(!pending));
            chk("cmd_valid0", 32'(if0.cmd_valid), 32'(pending));
            chk("cmd_valid1", 32'(if1.cmd_valid), 32'(pending));
            if (pending && exp0_q.size() > 0) begin
               cmp_cmd("d0", if0.cmd_signed, if0.cmd_int, if0.cmd_op, 32'(if0.cmd_src1),
                       32'(if0.cmd_src2), if0.cmd_err, if0.cmd_err_code, exp0_q[0]);
               cmp_cmd("d1", if1.cmd_signed, if1.cmd_int, if1.cmd_op, 32'(if1.cmd_src1),
                       32'(if1.cmd_src2), if1.cmd_err, if1.cmd_err_code, exp1_q[0]);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) cmd_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b);
      logic acc;
      rx_data  = b;
      rx_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
         acc = if0.rx_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
      if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic release_cmd();
      cmd_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_ready = 1'b0;
      chk("release_valid", 32'(if0.cmd_valid), 32'd0);
      chk("release_ready", 32'(if0.rx_ready), 32'd1);
   endtask

   function automatic logic [7:0] rand_hex();
      int n;
      n = int'($urandom_range(0, 15));
      if (n < 10) return 8'(48 + n);
      return 8'(($urandom_range(0, 1) != 0 ? 65 : 97) + n - 10);
   endfunction

   function automatic logic [7:0] rand_op();
      case ($urandom_range(0, 3))
         0: return "+";
         1: return "-";
         2: return "*";
         default: return "/";
      endcase
   endfunction

   function automatic logic [7:0] rand_junk();
      case ($urandom_range(0, 3))
         0: return "G";
         1: return "x";
         2: return "s";
         default: return "S";
      endcase
   endfunction

   function automatic int rand_len();
      int r;
      r = int'($urandom_range(0, 11));
      return (r == 0) ? 0 : (r == 11) ? 5 : 1 + (r % 4);
   endfunction

   task automatic gen_and_send();
      logic [7:0] q[$];
      int r;
      if ($urandom_range(0, 2) == 0)
         repeat ($urandom_range(1, 2)) begin
            case ($urandom_range(0, 3))
               0: q.push_back("S");
               1: q.push_back("U");
               2: q.push_back("I");
               default: q.push_back(" ");
            endcase
         end
      repeat (rand_len()) q.push_back(rand_hex());
      if ($urandom_range(0, 4) == 0) q.push_back(" ");
      r = int'($urandom_range(0, 11));
      if (r == 1) q.push_back(rand_junk());
      else if (r != 0) q.push_back(rand_op());
      repeat (rand_len()) q.push_back(rand_hex());
      if ($urandom_range(0, 14) == 0) q.insert(int'($urandom_range(0, q.size())), 8'h1B);
      if ($urandom_range(0, 14) == 0) q.insert(int'($urandom_range(0, q.size())), rand_junk());
      q.push_back("=");
      foreach (q[i]) send(q[i]);
   endtask

   exp_t pe;

   initial begin
      // Hand-computed expectations pinning the model.
      pe = model_s("1A+3", 4, 1'b1);
      chk("pin1_src1", pe.a, 32'h001A);
      chk("pin1_src2", pe.b, 32'h0003);
      chk("pin1_op", 32'(pe.op), 32'd1);
      chk("pin1_err", 32'(pe.err), 32'd0);
      pe = model_s("S F*2", 4, 1'b1);
      chk("pin2_src1", pe.a, 32'hFFFF);
      chk("pin2_signed", 32'(pe.sg), 32'd1);
      chk("pin2_op", 32'(pe.op), 32'd3);
      pe = model_s("U F*2", 4, 1'b1);
      chk("pin2u_src1", pe.a, 32'h000F);
      pe = model_s("12345+1", 4, 1'b1);
      chk("pin3_ovf", 32'(pe.code), 32'd2);
      pe = model_s("1G+2", 4, 1'b1);
      chk("pin3_bad", 32'(pe.code), 32'd1);
      pe = model_s("+2", 4, 1'b1);
      chk("pin3_syn1", 32'(pe.code), 32'd3);
      pe = model_s("5+", 4, 1'b1);
      chk("pin3_syn2", 32'(pe.code), 32'd3);
      pe = model_s("a+b", 4, 1'b1);
      chk("pin4_src2", pe.b, 32'h000B);
      pe = model_s("a+b", 4, 1'b0);
      chk("pin4_nolower", 32'(pe.code), 32'd1);

      #2 n_rst = 1'b0;
      #20;
      chk("rst_ready", 32'(if0.rx_ready), 32'd1);
      chk("rst_valid", 32'(if0.cmd_valid), 32'd0);
      chk("rst_src1", 32'(if0.cmd_src1), 32'd0);
      @(posedge clk);
      #1 n_rst = 1'b1;
      chk_en = 1'b1;

      send_str("1A+3=");
      chk("t1_valid", 32'(if0.cmd_valid), 32'd1);
      chk("t1_src1", 32'(if0.cmd_src1), 32'h001A);
      chk("t1_src2", 32'(if0.cmd_src2), 32'h0003);
      chk("t1_op", 32'(if0.cmd_op), 32'd1);
      chk("t1_err", 32'(if0.cmd_err), 32'd0);
      release_cmd();

      send_str("7/2=");
      for (int c = 0; c < 5; c++) begin
         rx_data  = "9";
         rx_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(if0.cmd_valid), 32'd1);
         chk("hold_src1", 32'(if0.cmd_src1), 32'h0007);
         chk("hold_ready", 32'(if0.rx_ready), 32'd0);
      end
      rx_valid = 1'b0;
      release_cmd();
      send_str("1-1=");
      chk("t5_src1", 32'(if0.cmd_src1), 32'h0001);
      chk("t5_op", 32'(if0.cmd_op), 32'd2);
      release_cmd();

      send_str("12+");
      send(8'h1B);
      send_str("3-1=");
      chk("t6_src1", 32'(if0.cmd_src1), 32'h0003);
      chk("t6_src2", 32'(if0.cmd_src2), 32'h0001);
      chk("t6_op", 32'(if0.cmd_op), 32'd2);
      release_cmd();

      send_str("12");
      n_rst = 1'b0;
      #3;
      chk("rstm_src1", 32'(if0.cmd_src1), 32'd0);
      chk("rstm_err", 32'(if0.cmd_err), 32'd0);
      chk("rstm_ready", 32'(if0.rx_ready), 32'd1);
      @(posedge clk);
      #1 n_rst = 1'b1;

      rdy_rand = 1'b1;
      gap_en   = 1'b1;
      send_str("S F*2=");
      send_str("U F*2=");
      send_str("12345+1=");
      send_str("1G+2=");
      send_str("+2=");
      send_str("5+=");
      send_str("a+b=");
      send_str("SI 8 + 7F=");
      repeat (300) gen_and_send();

      rdy_rand  = 1'b0;
      cmd_ready = 1'b1;
      for (int t = 0; t < 50 && pending; t++) begin @(posedge clk); #1; end
      if (pending) chk("drain_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
